// File: rtl/sysbus_arbiter.sv
// sysbus_arbiter: round-robin arbiter sharing one Sysbus port between fetch (m0) and data (m1)
module sysbus_arbiter #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int BEATS          = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      m0_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] m0_req,
    input  logic [BUS_TAG_WIDTH-1:0]  m0_reqtag,
    input  logic [BUS_DATA_WIDTH-1:0] m0_wdata,
    output logic                      m0_reqack,
    output logic                      m0_wready,
    output logic                      m0_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] m0_resp,
    output logic [BUS_TAG_WIDTH-1:0]  m0_resptag,
    input  logic                      m1_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] m1_req,
    input  logic [BUS_TAG_WIDTH-1:0]  m1_reqtag,
    input  logic [BUS_DATA_WIDTH-1:0] m1_wdata,
    output logic                      m1_reqack,
    output logic                      m1_wready,
    output logic                      m1_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] m1_resp,
    output logic [BUS_TAG_WIDTH-1:0]  m1_resptag,
    output logic                      bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    output logic                      bus_respack,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag
);
    localparam int CW = $clog2(BEATS) + 1;

    typedef enum logic [1:0] {IDLE, REQ, WDATA, RDATA} state_t;

    state_t state, state_nx;
    logic owner;
    logic prio;
    logic [BUS_DATA_WIDTH-1:0] addr;
    logic [BUS_TAG_WIDTH-1:0] tag;
    logic [CW-1:0] cnt;
    logic gnt_any, gnt_m1, last_beat, act, in_req, in_wr, in_rd, rack;

    // prio=1 means m1 is favoured when both masters request together
    assign gnt_any   = m0_reqcyc || m1_reqcyc;
    assign gnt_m1    = m1_reqcyc && (!m0_reqcyc || prio);
    assign last_beat = cnt == CW'(BEATS - 1);

    // state register plus latched grant, priority pointer and beat counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            owner <= 1'b0;
            prio  <= 1'b0;
            addr  <= '0;
            tag   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && gnt_any) begin
                owner <= gnt_m1;
                addr  <= gnt_m1 ? m1_req : m0_req;
                tag   <= gnt_m1 ? m1_reqtag : m0_reqtag;
                cnt   <= '0;
            end
            if (state == REQ && bus_reqack)
                prio <= ~owner;
            if (state == WDATA || (state == RDATA && bus_respcyc))
                cnt <= cnt + CW'(1);
        end
    end

    // next-state: tag MSB set means read, clear means write
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = gnt_any ? REQ : IDLE;
            REQ:     state_nx = !bus_reqack ? REQ : tag[BUS_TAG_WIDTH-1] ? RDATA : WDATA;
            WDATA:   state_nx = last_beat ? IDLE : WDATA;
            RDATA:   state_nx = (bus_respcyc && last_beat) ? IDLE : RDATA;
            default: state_nx = IDLE;
        endcase
    end

    // outputs are forced low while reset is held, whatever the state register holds
    assign act    = !reset;
    assign in_req = act && state == REQ;
    assign in_wr  = act && state == WDATA;
    assign in_rd  = act && state == RDATA;
    assign rack   = in_req && bus_reqack;

    assign bus_reqcyc  = in_req || in_wr;
    assign bus_req     = in_req ? addr : in_wr ? (owner ? m1_wdata : m0_wdata) : '0;
    assign bus_reqtag  = (in_req || in_wr) ? tag : '0;
    assign bus_respack = act && bus_respcyc;

    assign m0_reqack  = rack && !owner;
    assign m1_reqack  = rack && owner;
    assign m0_wready  = in_wr && !owner;
    assign m1_wready  = in_wr && owner;
    assign m0_respcyc = in_rd && !owner && bus_respcyc;
    assign m1_respcyc = in_rd && owner && bus_respcyc;
    assign m0_resp    = (in_rd && !owner) ? bus_resp : '0;
    assign m1_resp    = (in_rd && owner) ? bus_resp : '0;
    assign m0_resptag = (in_rd && !owner) ? bus_resptag : '0;
    assign m1_resptag = (in_rd && owner) ? bus_resptag : '0;
endmodule

// File: tb/tb_sysbus_arbiter.sv
// tb_sysbus_arbiter: vector table, corner sequences and randomized transactions against a transaction-level model
module tb_sysbus_arbiter;
    localparam int BEATS = 8;

    logic clk = 0, reset = 1;
    logic m0_reqcyc = 0, m1_reqcyc = 0, bus_reqack = 0, bus_respcyc = 0;
    logic [63:0] m0_req = 0, m1_req = 0, m0_wdata = 0, m1_wdata = 0, bus_resp = 0;
    logic [12:0] m0_reqtag = 0, m1_reqtag = 0, bus_resptag = 0;
    logic m0_reqack, m0_wready, m0_respcyc, m1_reqack, m1_wready, m1_respcyc;
    logic bus_reqcyc, bus_respack;
    logic [63:0] m0_resp, m1_resp, bus_req;
    logic [12:0] m0_resptag, m1_resptag, bus_reqtag;

    int n_cmp = 0, n_bad = 0;
    bit pend[2];
    logic [63:0] addr[2];
    logic [12:0] tag[2];
    int fav = 0;

    typedef struct {
        bit rst; bit r0; bit r1;
        logic [63:0] a0; logic [63:0] a1;
        logic [12:0] t0; logic [12:0] t1;
        int own; int rdly; logic [31:0] gaps;
    } vec_t;
    vec_t tv[9];

    sysbus_arbiter dut (
        .clk(clk), .reset(reset),
        .m0_reqcyc(m0_reqcyc), .m0_req(m0_req), .m0_reqtag(m0_reqtag), .m0_wdata(m0_wdata),
        .m0_reqack(m0_reqack), .m0_wready(m0_wready), .m0_respcyc(m0_respcyc),
        .m0_resp(m0_resp), .m0_resptag(m0_resptag),
        .m1_reqcyc(m1_reqcyc), .m1_req(m1_req), .m1_reqtag(m1_reqtag), .m1_wdata(m1_wdata),
        .m1_reqack(m1_reqack), .m1_wready(m1_wready), .m1_respcyc(m1_respcyc),
        .m1_resp(m1_resp), .m1_resptag(m1_resptag),
        .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag),
        .bus_respack(bus_respack), .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc),
        .bus_resp(bus_resp), .bus_resptag(bus_resptag)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] ctl();
        return {bus_reqcyc, m0_reqack, m1_reqack, m0_wready, m1_wready, m0_respcyc, m1_respcyc, bus_respack};
    endfunction

    task automatic drive_req();
        m0_reqcyc = pend[0]; m0_req = addr[0]; m0_reqtag = tag[0];
        m1_reqcyc = pend[1]; m1_req = addr[1]; m1_reqtag = tag[1];
    endtask

    task automatic tick();
        @(posedge clk); #1;
        drive_req();
        bus_reqack = 0;
        bus_respcyc = 0;
        bus_resp = {$urandom, $urandom};
        bus_resptag = 13'($urandom);
        m0_wdata = {$urandom, $urandom};
        m1_wdata = {$urandom, $urandom};
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1;
        pend = '{0, 0};
        drive_req();
        bus_reqack = 1;
        bus_respcyc = 1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_ctl", 64'(ctl()), 0);
        chk("rst_bus_req", bus_req, 0);
        chk("rst_bus_tag", 64'(bus_reqtag), 0);
        chk("rst_resp", m0_resp | m1_resp, 0);
        chk("rst_resptag", 64'(m0_resptag | m1_resptag), 0);
        @(posedge clk); #1;
        reset = 0;
        bus_reqack = 0;
        bus_respcyc = 0;
        fav = 0;
        @(negedge clk);
        chk("post_rst_ctl", 64'(ctl()), 0);
    endtask

    // One whole transaction starting from an idle bus; eo is the master expected to win.
    // Stops early after beat number 'abort' of a read when abort > 0.
    task automatic serve(input int eo, input int rdly, input logic [31:0] gaps, input int abort, input bit stray);
        bit rd;
        int g;
        logic [63:0] wd;
        rd = tag[eo][12];
        tick();
        bus_respcyc = stray;
        @(negedge clk);
        chk("idle_ctl", 64'(ctl()), 64'({7'b0, stray}));
        for (int d = 0; d <= rdly; d++) begin
            tick();
            bus_reqack = (d == rdly);
            bus_respcyc = stray && d == 0;
            @(negedge clk);
            chk("req_ctl", 64'(ctl()), 64'({1'b1, eo == 0 && d == rdly, eo == 1 && d == rdly, 4'b0, bus_respcyc}));
            chk("req_addr", bus_req, addr[eo]);
            chk("req_tag", 64'(bus_reqtag), 64'(tag[eo]));
        end
        pend[eo] = 0;
        fav = 1 - eo;
        if (!rd) begin
            for (int b = 0; b < BEATS; b++) begin
                tick();
                @(negedge clk);
                wd = eo ? m1_wdata : m0_wdata;
                chk("wr_ctl", 64'(ctl()), 64'({1'b1, 2'b0, eo == 0, eo == 1, 3'b0}));
                chk("wr_data", bus_req, wd);
            end
        end else begin
            for (int b = 0; b < BEATS; b++) begin
                g = int'(gaps[4*b +: 4]);
                for (int k = 0; k < g; k++) begin
                    tick();
                    @(negedge clk);
                    chk("rd_gap_ctl", 64'(ctl()), 0);
                end
                tick();
                bus_respcyc = 1;
                @(negedge clk);
                chk("rd_beat_ctl", 64'(ctl()), 64'({5'b0, eo == 0, eo == 1, 1'b1}));
                chk("rd_data", eo ? m1_resp : m0_resp, bus_resp);
                chk("rd_tag", 64'(eo ? m1_resptag : m0_resptag), 64'(bus_resptag));
                if (b + 1 == abort) return;
            end
        end
    endtask

    initial begin
        int eo;
        pend = '{0, 0};
        addr = '{0, 0};
        tag = '{0, 0};
        tv[0] = '{1, 1, 0, 64'h1000, 64'h0,    13'h1100, 13'h0,    0, 3, 32'h0};
        tv[1] = '{1, 1, 1, 64'h1040, 64'h3000, 13'h1100, 13'h1100, 0, 0, 32'h0};
        tv[2] = '{0, 1, 0, 64'h1080, 64'h0,    13'h1100, 13'h0,    1, 1, 32'h0};
        tv[3] = '{0, 0, 1, 64'h0,    64'h3040, 13'h0,    13'h1100, 0, 0, 32'h0};
        tv[4] = '{0, 0, 0, 64'h0,    64'h0,    13'h0,    13'h0,    1, 2, 32'h0};
        tv[5] = '{0, 0, 1, 64'h0,    64'h2000, 13'h0,    13'h0100, 1, 1, 32'h0};
        tv[6] = '{0, 1, 0, 64'h1100, 64'h0,    13'h1100, 13'h0,    0, 0, 32'h0004_0200};
        tv[7] = '{0, 1, 1, 64'h40,   64'h5000, 13'h0100, 13'h1300, 1, 0, 32'h0};
        tv[8] = '{0, 0, 0, 64'h0,    64'h0,    13'h0,    13'h0,    0, 2, 32'h0};

        for (int i = 0; i < 9; i++) begin
            if (tv[i].rst) do_reset();
            if (tv[i].r0) begin pend[0] = 1; addr[0] = tv[i].a0; tag[0] = tv[i].t0; end
            if (tv[i].r1) begin pend[1] = 1; addr[1] = tv[i].a1; tag[1] = tv[i].t1; end
            serve(tv[i].own, tv[i].rdly, tv[i].gaps, -1, 0);
        end

        // stray response beat with the bus idle
        tick();
        bus_respcyc = 1;
        @(negedge clk);
        chk("stray_ctl", 64'(ctl()), 64'h01);
        chk("stray_resp", m0_resp | m1_resp, 0);
        tick();
        @(negedge clk);
        chk("stray_after_ctl", 64'(ctl()), 0);

        // reset in the middle of a read, then pointer must favour m0 again
        pend[0] = 1; addr[0] = 64'h7000; tag[0] = 13'h1100;
        serve(0, 1, 32'h0, 3, 0);
        @(posedge clk); #1;
        reset = 1;
        bus_respcyc = 1;
        @(negedge clk);
        chk("rst_mid_ctl", 64'(ctl()), 0);
        chk("rst_mid_req", bus_req, 0);
        chk("rst_mid_resp", m0_resp, 0);
        @(posedge clk); #1;
        reset = 0;
        bus_respcyc = 0;
        fav = 0;
        @(negedge clk);
        chk("rst_mid_after_ctl", 64'(ctl()), 0);
        pend = '{1, 1}; addr = '{64'h7100, 64'h8000}; tag = '{13'h1100, 13'h1100};
        serve(0, 0, 32'h0, -1, 0);
        serve(1, 0, 32'h1010_0101, -1, 0);
        pend[1] = 1; addr[1] = 64'h8040; tag[1] = 13'h0100;
        serve(1, 0, 32'h0, -1, 1);

        // randomized transactions, owner predicted from round-robin rules
        for (int t = 0; t < 40; t++) begin
            for (int m = 0; m < 2; m++)
                if (!pend[m] && $urandom_range(0, 1) == 1) begin
                    pend[m] = 1; addr[m] = {$urandom, $urandom}; tag[m] = 13'($urandom);
                end
            if (!pend[0] && !pend[1]) begin
                eo = int'($urandom_range(0, 1));
                pend[eo] = 1; addr[eo] = {$urandom, $urandom}; tag[eo] = 13'($urandom);
            end
            eo = (pend[0] && pend[1]) ? fav : (pend[0] ? 0 : 1);
            serve(eo, int'($urandom_range(0, 3)), $urandom & 32'h3333_3333, -1, 1'($urandom_range(0, 1)));
        end

        tick();
        @(negedge clk);
        chk("final_idle_ctl", 64'(ctl()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sysbus_arbiter.md
Name: sysbus_arbiter

Overview:
Two-master arbiter that shares the single Sysbus port between the instruction-fetch unit (master 0) and the data-memory unit (master 1).
It grants one transaction at a time with round-robin fairness and drives the request/address phase. For writes it streams the write-data beats; for reads it routes the response beats back to the owning master and generates bus_respack.
It sits between the core's fetch/LSU logic and the top-level bus pins.

Parameters:
BUS_DATA_WIDTH, 64, data/address width of bus and master ports
BUS_TAG_WIDTH, 13, tag width; bit 12 = SYSBUS_READ/WRITE, bits 11:8 = SYSBUS type
BEATS, 8, beats per transaction (64-byte line / 8 bytes)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
mN_reqcyc  in  1  master N (N=0,1) request valid
mN_req  in  BUS_DATA_WIDTH  master N address
mN_reqtag  in  BUS_TAG_WIDTH  master N tag
mN_wdata  in  BUS_DATA_WIDTH  master N write beat
mN_reqack  out  1  request accepted by bus (1-cycle pulse)
mN_wready  out  1  current mN_wdata beat consumed this cycle
mN_respcyc  out  1  read beat valid for master N
mN_resp  out  BUS_DATA_WIDTH  read beat data
mN_resptag  out  BUS_TAG_WIDTH  read beat tag
bus_reqcyc  out  1  to Sysbus
bus_req  out  BUS_DATA_WIDTH  to Sysbus (address, then write data)
bus_reqtag  out  BUS_TAG_WIDTH  to Sysbus
bus_respack  out  1  to Sysbus
bus_reqack  in  1  from Sysbus
bus_respcyc  in  1  from Sysbus
bus_resp  in  BUS_DATA_WIDTH  from Sysbus
bus_resptag  in  BUS_TAG_WIDTH  from Sysbus

Behaviour:
- One clock domain (clk); reset is synchronous, active-high. Reset, including mid-transaction, forces IDLE, beat counter 0, priority pointer favouring m0. All outputs are 0 during and after reset until a grant.
- FSM states: IDLE, REQ, WDATA, RDATA.
- IDLE:
  - Sample m0_reqcyc/m1_reqcyc. If exactly one is high, grant it. If both are high, grant the master not granted last; after reset this is m0.
  - On grant, register owner, address and tag, go to REQ. bus_reqcyc rises the next cycle (1-cycle grant latency).
- REQ:
  - bus_reqcyc=1; bus_req and bus_reqtag hold the owner's latched address and tag, stable until bus_reqack.
  - On bus_reqack=1: pulse owner mN_reqack combinationally in that cycle and update the priority pointer.
  - Next state is WDATA if tag[12]=WRITE, else RDATA.
- WDATA:
  - bus_reqcyc=1, bus_req=owner mN_wdata, owner mN_wready=1 each cycle; no per-beat backpressure.
  - After BEATS cycles go to IDLE with bus_reqcyc=0.
- RDATA:
  - bus_respack = bus_respcyc (same cycle).
  - Owner mN_respcyc = bus_respcyc; mN_resp/mN_resptag = bus_resp/bus_resptag, combinational pass-through. The non-owner's respcyc stays 0.
  - Count beats; on the BEATS-th beat go to IDLE the next cycle. Idle cycles between beats are allowed.
- bus_respcyc seen in IDLE/REQ/WDATA (stray beat): assert bus_respack, forward to no master, do not count.
- Grants are never pre-empted. A master must drop reqcyc after its reqack; reqcyc still high in IDLE counts as a new request.
- Back-to-back: earliest re-grant is the cycle after return to IDLE; minimum gap between transactions is 1 cycle with bus_reqcyc=0.
- Beat counter is $clog2(BEATS)+1 bits; it resets to 0 on every grant, so no wrap.
- mN_reqack, mN_wready and mN_respcyc are one-hot across masters and never asserted in IDLE.

Test Plan:
- Reset, then m0 read at 0x1000 with tag {READ,MEMORY}=0x1100 -> bus_reqcyc=1 with bus_req=0x1000 one cycle later. bus_reqack at cycle 5 -> m0_reqack pulse. 8 bus_respcyc beats -> 8 m0_respcyc with matching data and bus_respack each beat; m1_respcyc stays 0.
- m0 and m1 both request on the same cycle after reset -> m0 granted first, then m1. Both re-request -> m0 next; strict alternation over 4 transactions.
- m1 write to 0x2000 (tag bit12=WRITE) -> after reqack, 8 consecutive cycles with bus_req = m1_wdata and m1_wready=1, then bus_reqcyc=0.
- Read with bubbles: beats arrive at cycles 10, 11, 14, 15, 20–23 -> return to IDLE only after the 8th beat; no early exit.
- Reset asserted during RDATA after beat 3 -> next cycle all outputs 0, state IDLE. A fresh m1 request wins over m0 only if m0 is idle.
- Stray bus_respcyc in IDLE -> bus_respack=1, m0_respcyc=m1_respcyc=0, no state change.
